mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates a fetch port and a data port onto one single-port
//            memory, with a bounded data streak so fetches cannot starve.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_grant_i;
  logic        w_grant_d;
  logic [3:0]  r_streak;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_ready;
  logic        r_d_ready;

  // Data wins a collision unless it has already taken its full streak.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req && (!if_req || (r_streak != c_max_streak))) begin
          w_next    = S_GNT_D;
          w_grant_d = 1'b1;
        end else if (if_req) begin
          w_next    = S_GNT_I;
          w_grant_i = 1'b1;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (mem_ack) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_streak    <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_rdata  <= 32'h0;
      r_d_rdata   <= 32'h0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      if (w_grant_i) begin
        r_streak    <= 4'd0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= 4'hF;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= 32'h0;
      end else if (w_grant_d) begin
        if (!if_req) begin
          r_streak <= 4'd0;
        end else if (r_streak < c_max_streak) begin
          r_streak <= r_streak + 4'd1;
        end
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_be    <= d_be;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if ((r_state != S_IDLE) && mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == S_GNT_I) begin
          r_if_rdata <= mem_rdata;
          r_if_ready <= 1'b1;
        end else begin
          if (!r_mem_we) begin
            r_d_rdata <= mem_rdata;
          end
          r_d_ready <= 1'b1;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign if_stall  = if_req & ~r_if_ready;
  assign d_stall   = d_req & ~r_d_ready;

endmodule
`default_nettype wire
